// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width for n entries; never below one bit so single-master builds still have a port.
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the core masters, the arbiter and the downstream memory port.
interface mem_arbiter_if #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_MST-1:0]            req_valid;
  logic [N_MST-1:0]            req_ready;
  logic [N_MST-1:0]            req_wen;
  logic [N_MST*ADDR_W-1:0]     req_addr;
  logic [N_MST*DATA_W-1:0]     req_wdata;
  logic [N_MST*DATA_W/8-1:0]   req_wmask;
  logic [N_MST-1:0]            rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic [N_MST-1:0]            rsp_ready;
  logic                        mem_req_valid;
  logic                        mem_req_ready;
  logic                        mem_wen;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W/8-1:0]         mem_wmask;
  logic                        mem_rsp_valid;
  logic [DATA_W-1:0]           mem_rsp_rdata;
  logic                        mem_rsp_ready;

  // Environment side: requesting masters plus the downstream memory model.
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rsp_ready
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rsp_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational pick of one requester: scan starts at ptr in round-robin mode, at 0 in fixed mode.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] base_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;
  logic             hit_s;

  // First requester at or after the scan base, modulo N.
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    base_s = mode ? ptr : '0;
    for (int k = 0; k < N; k++) begin
      sum_s  = {1'b0, base_s} + (IDX_W+1)'(k);
      cand_s = (sum_s >= (IDX_W+1)'(N)) ? IDX_W'(sum_s - (IDX_W+1)'(N)) : sum_s[IDX_W-1:0];
      hit_s  = ~any & req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-master to single memory port arbiter with one outstanding ready/valid transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_MST   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = ARB_RR
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W  = idx_width(N_MST);
  localparam int MASK_W = DATA_W / 8;

  arb_state_e         state_r;
  arb_state_e         state_nx_s;
  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   grant_r;
  logic               wen_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [MASK_W-1:0]  wmask_r;
  logic [DATA_W-1:0]  rdata_r;

  logic [N_MST-1:0]   arb_grant_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               arb_any_s;
  logic               arb_mode_s;
  logic [N_MST-1:0]   grant_oh_s;
  logic [IDX_W-1:0]   ptr_nx_s;

  assign arb_mode_s = (RR_MODE == ARB_RR) ? 1'b1 : 1'b0;
  assign ptr_nx_s   = (arb_idx_s == IDX_W'(N_MST - 1)) ? '0 : arb_idx_s + IDX_W'(1);

  rr_arbiter #(
    .N     (N_MST),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req   (bus.req_valid),
    .ptr   (ptr_r),
    .mode  (arb_mode_s),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .any   (arb_any_s)
  );

  // One-hot decode of the latched grant for the response valid vector.
  always_comb begin
    grant_oh_s = '0;
    for (int i = 0; i < N_MST; i++) begin
      grant_oh_s[i] = (grant_r == IDX_W'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and state-decoded handshake outputs; req_ready is forced low while reset is held.
  always_comb begin
    state_nx_s        = state_r;
    bus.req_ready     = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_rsp_ready = 1'b0;
    bus.rsp_valid     = '0;
    case (state_r)
      IDLE: begin
        bus.req_ready = sys_rst ? '0 : arb_grant_s;
        state_nx_s    = arb_any_s ? REQ : IDLE;
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        state_nx_s        = bus.mem_req_ready ? WAIT : REQ;
      end
      WAIT: begin
        bus.mem_rsp_ready = 1'b1;
        state_nx_s        = bus.mem_rsp_valid ? RESP : WAIT;
      end
      RESP: begin
        bus.rsp_valid = grant_oh_s;
        state_nx_s    = bus.rsp_ready[grant_r] ? IDLE : RESP;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Request latch on grant, priority pointer update, read data capture in WAIT.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_r   <= '0;
      grant_r <= '0;
      wen_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wmask_r <= '0;
      rdata_r <= '0;
    end else begin
      if ((state_r == IDLE) && arb_any_s) begin
        grant_r <= arb_idx_s;
        wen_r   <= bus.req_wen[arb_idx_s];
        addr_r  <= bus.req_addr[int'(arb_idx_s)*ADDR_W +: ADDR_W];
        wdata_r <= bus.req_wdata[int'(arb_idx_s)*DATA_W +: DATA_W];
        wmask_r <= bus.req_wmask[int'(arb_idx_s)*MASK_W +: MASK_W];
        ptr_r   <= arb_mode_s ? ptr_nx_s : '0;
      end
      if ((state_r == WAIT) && bus.mem_rsp_valid) begin
        rdata_r <= wen_r ? '0 : bus.mem_rsp_rdata;
      end
    end
  end

  assign bus.mem_wen   = wen_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_wmask = wmask_r;
  assign bus.rsp_rdata = rdata_r;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-master memory arbiter that replaces the fixed single-cycle instruction-fetch/load-store memory path with a ready/valid handshake. It sits between the core's requesters (IFU fetch port, LSU data port, optional debug/DMA ports) and one downstream memory port. It grants one transaction at a time, by either fixed priority or round-robin, and returns read data to the granted master. There is exactly one outstanding transaction and memory latency is variable.

## Interface
- N_MST, 2: number of master channels (1..8); master 0 is highest priority in fixed mode.
- ADDR_W, 32: address width.
- DATA_W, 32: data width (multiple of 8); mask width is DATA_W/8.
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority.

- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  reset; asynchronous and active-high.
- req_valid  in  N_MST  per-master request valid.
- req_ready  out  N_MST  per-master request accepted (one-hot or zero).
- req_wen  in  N_MST  1 = write, 0 = read.
- req_addr  in  N_MST*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_MST*DATA_W  packed write data.
- req_wmask  in  N_MST*DATA_W/8  packed byte enables.
- rsp_valid  out  N_MST  response valid to the granted master only.
- rsp_rdata  out  DATA_W  shared response data; read data for reads, 0 for writes.
- rsp_ready  in  N_MST  per-master response accept.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream request accept.
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields.
- mem_rsp_valid  in  1  downstream response valid (writes also respond).
- mem_rsp_rdata  in  DATA_W  downstream read data.
- mem_rsp_ready  out  1  downstream response accept.

## Operation
- FSM states are IDLE, REQ, WAIT and RESP.
- IDLE
  - The arbiter picks a winner among the req_valid bits.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On the handshake, the request fields and grant index are latched.
  - The FSM then moves to REQ.
- REQ: mem_req_valid=1 with the latched fields, which stay stable. On mem_req_ready the FSM moves to WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid, rdata is latched (0 if wen) and the FSM moves to RESP.
- RESP
  - rsp_valid[grant]=1 and rsp_rdata holds the latched data, both stable.
  - On rsp_ready[grant] the FSM returns to IDLE.
  - rsp_ready from other masters is ignored.
- Round-robin
  - A priority pointer ptr is used.
  - The winner is the first valid master scanning ptr, ptr+1, … mod N_MST.
  - On grant, ptr ← winner+1, wrapping N_MST-1 → 0.
- Fixed mode: the lowest-index valid master wins; ptr is unused and held at 0.
- Masters must hold request fields stable while req_valid=1 and req_ready=0. Dropping req_valid before the handshake is legal and has no effect.
- mem_rsp_valid outside WAIT is a protocol error. It is ignored, with no state change.
- Reset, including mid-transaction:
  - The FSM goes to IDLE, ptr goes to 0, and the grant and all data registers go to 0.
  - Any in-flight transaction is dropped and no response is issued.
  - All outputs are 0 during and after reset until the next request.

## Timing
- Request accepted in cycle t gives mem_req_valid at t+1.
- With mem_req_ready=1 at t+1 and mem_rsp_valid at t+2, rsp_valid is asserted at t+3. This is the minimum 3-cycle latency.
- Each downstream stall cycle (mem_req_ready=0 or late mem_rsp_valid) adds one cycle.
- The next grant is possible in the cycle after the rsp handshake, so peak throughput is 1 transaction per 4 cycles.
- req_ready is combinational from req_valid and ptr, and only in IDLE. Every other output is registered or decoded from the FSM state.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, REQ, WAIT, RESP};
  - RR_MODE constants ARB_FIXED=0 and ARB_RR=1;
  - a function computing clog2-based index width.
- Sub-module rr_arbiter (combinational):
  - inputs: req vector, ptr, mode;
  - outputs: one-hot grant and index.
- The top instantiates rr_arbiter and holds the FSM, ptr and the latched-request/response registers.

## Test plan
- Single read, N_MST=2, RR: master 0 reads addr 0x8000_0000 and memory answers 0xDEAD_BEEF with zero latency → rsp_valid[0] at t+3, rsp_rdata=0xDEAD_BEEF, rsp_valid[1]=0 throughout.
- Round-robin fairness: both masters continuously valid for 6 transactions → grant order 0,1,0,1,0,1.
- Fixed mode (RR_MODE=0): both masters continuously valid → master 0 is granted every time while master 1 waits.
- Downstream stalls: mem_req_ready low for 3 cycles, then mem_rsp_valid 2 cycles after acceptance → mem_addr/mem_wdata stable during the stall, rsp_valid at t+3+3+1.
- Write plus back-pressure: master 1 writes 0x1234_5678 with wmask 4'b0011 and holds rsp_ready low for 4 cycles → rsp_valid[1] held with rsp_rdata=0, and no new grant until rsp_ready.
- Reset in WAIT: sys_rst asserted asynchronously mid-cycle → all outputs 0 immediately, then a late mem_rsp_valid is ignored and the next request is granted from ptr=0.
